// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder
//  Description : Parameterised pipelined carry-lookahead adder/subtractor.
//                The operand is split into 4-bit lookahead groups; each
//                pipeline stage resolves GROUPS_PER_STAGE of them, and the
//                group carry is registered between stages. Operand bits not
//                yet consumed and sum bits already produced ride along in the
//                stage registers, so the result leaves the last stage aligned.
//                A single global stall freezes every stage while the output
//                holds a result that the consumer has not yet taken.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH             operand width, multiple of 4, 4..64
//    GROUPS_PER_STAGE  4-bit groups per stage, must divide WIDTH/4
//  Ports
//    clk        in   rising-edge clock
//    reset      in   asynchronous active-high reset
//    in_valid   in   operand beat offered
//    in_ready   out  beat accepted this cycle when in_valid is also high
//    a, b       in   operands [WIDTH-1:0]
//    c_in       in   carry in (ignored when sub=1)
//    sub        in   0: a+b+c_in   1: a-b
//    out_valid  out  result beat present
//    out_ready  in   consumer takes the result
//    s          out  sum / difference [WIDTH-1:0]
//    c_out      out  carry out of the MSB (for sub: 1 = no borrow)
//    overflow   out  two's-complement signed overflow
//  Latency is WIDTH/(4*GROUPS_PER_STAGE) cycles from acceptance to out_valid.
// ============================================================================
module pipelined_cla_adder #(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);

  localparam int c_slice  = 4 * GROUPS_PER_STAGE;   // bits resolved per stage
  localparam int c_stages = WIDTH / c_slice;        // pipeline depth L

  // --------------------------------------------------------------------------
  // 4-bit group with full two-level lookahead: every carry is a flat
  // sum-of-products of g, p and the group carry-in (no internal ripple).
  // Returns {carry_out, sum[3:0]}.
  // --------------------------------------------------------------------------
  function automatic logic [4:0] cla4(input logic [3:0] fa,
                                      input logic [3:0] fb,
                                      input logic       fc);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    g  = fa & fb;
    p  = fa | fb;
    c1 = g[0] | (p[0] & fc);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & fc);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & fc);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & fc);
    return {c4, fa ^ fb ^ {c3, c2, c1, fc}};
  endfunction

  // Stage registers (index k = stage k output)
  logic [WIDTH-1:0] r_a  [c_stages];
  logic [WIDTH-1:0] r_b  [c_stages];
  logic [WIDTH-1:0] r_s  [c_stages];
  logic             r_c  [c_stages];
  logic             r_ov [c_stages];
  logic             r_v  [c_stages];

  // Next-state values produced by each stage's combinational slice
  logic [WIDTH-1:0] w_a_n  [c_stages];
  logic [WIDTH-1:0] w_b_n  [c_stages];
  logic [WIDTH-1:0] w_s_n  [c_stages];
  logic             w_c_n  [c_stages];
  logic             w_ov_n [c_stages];
  logic             w_v_n  [c_stages];

  logic w_adv;

  // Global advance: everything moves unless the output is blocked.
  assign w_adv     = ~(out_valid & ~out_ready);
  assign in_ready  = w_adv & ~reset;

  for (genvar k = 0; k < c_stages; k++) begin : g_stage
    logic [WIDTH-1:0]        w_a_i;
    logic [WIDTH-1:0]        w_b_i;
    logic [WIDTH-1:0]        w_s_i;
    logic [WIDTH-1:0]        w_s_m;
    logic                    w_c_i;
    logic                    w_v_i;
    logic [GROUPS_PER_STAGE:0] w_cc;
    logic [c_slice-1:0]      w_sg;

    if (k == 0) begin : g_head
      // Subtraction folds into addition: a + ~b + 1.
      assign w_a_i = a;
      assign w_b_i = sub ? ~b : b;
      assign w_s_i = '0;
      assign w_c_i = sub ? 1'b1 : c_in;
      assign w_v_i = in_valid;
    end else begin : g_body
      assign w_a_i = r_a[k-1];
      assign w_b_i = r_b[k-1];
      assign w_s_i = r_s[k-1];
      assign w_c_i = r_c[k-1];
      assign w_v_i = r_v[k-1];
    end

    // Groups inside one stage chain their carries combinationally.
    assign w_cc[0] = w_c_i;
    for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_grp
      localparam int c_lsb = (k * GROUPS_PER_STAGE + j) * 4;
      assign {w_cc[j+1], w_sg[4*j +: 4]} =
        cla4(w_a_i[c_lsb +: 4], w_b_i[c_lsb +: 4], w_cc[j]);
    end

    // Splice this stage's sum bits into the travelling result word.
    always_comb begin
      w_s_m = w_s_i;
      w_s_m[k*c_slice +: c_slice] = w_sg;
    end

    assign w_a_n[k]  = w_a_i;
    assign w_b_n[k]  = w_b_i;
    assign w_s_n[k]  = w_s_m;
    assign w_c_n[k]  = w_cc[GROUPS_PER_STAGE];
    assign w_v_n[k]  = w_v_i;
    // Carry into the MSB is a^b'^s at that bit; overflow is it XOR carry-out.
    // Only the final stage's value is meaningful.
    assign w_ov_n[k] = w_a_i[WIDTH-1] ^ w_b_i[WIDTH-1] ^ w_s_m[WIDTH-1]
                       ^ w_cc[GROUPS_PER_STAGE];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < c_stages; k++) begin
        r_a[k]  <= '0;
        r_b[k]  <= '0;
        r_s[k]  <= '0;
        r_c[k]  <= 1'b0;
        r_ov[k] <= 1'b0;
        r_v[k]  <= 1'b0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < c_stages; k++) begin
        r_a[k]  <= w_a_n[k];
        r_b[k]  <= w_b_n[k];
        r_s[k]  <= w_s_n[k];
        r_c[k]  <= w_c_n[k];
        r_ov[k] <= w_ov_n[k];
        r_v[k]  <= w_v_n[k];
      end
    end
  end

  // The last stage register doubles as the output register.
  assign out_valid = r_v[c_stages-1];
  assign s         = r_s[c_stages-1];
  assign c_out     = r_c[c_stages-1];
  assign overflow  = r_ov[c_stages-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_cla_adder
//  Description : Self-checking bench for pipelined_cla_adder (WIDTH=16,
//                GROUPS_PER_STAGE=1, latency 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        c_out;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_cla_adder #(
    .WIDTH            (16),
    .GROUPS_PER_STAGE (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, c_out, s} of a + b' + cin'
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] bp;
    logic        ci;
    logic [16:0] sum;
    logic        ov;
    bp  = ms ? ~mb : mb;
    ci  = ms ? 1'b1 : mc;
    sum = {1'b0, ma} + {1'b0, bp} + {16'b0, ci};
    ov  = (ma[15] == bp[15]) && (sum[15] != ma[15]);
    return {ov, sum};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
    a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    tick(); tick();
    n_tests++;
    if (out_valid !== 1'b0 || {overflow, c_out, s} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b ov/c/s=%h, want v=0 ov/c/s=00000", out_valid, {overflow, c_out, s});
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, want 0", in_ready);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_single_beats();
    logic [15:0] ta [6];
    logic [15:0] tb_ [6];
    logic        tc [6];
    logic        ts [6];
    logic [17:0] te [6];
    ta  = '{16'hFFFF, 16'h7FFF, 16'h0003, 16'h0000, 16'h8000, 16'h0005};
    tb_ = '{16'h0001, 16'h0001, 16'h0005, 16'h0000, 16'h8000, 16'h0005};
    tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ts  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    te  = '{18'h10000, 18'h28000, 18'h0FFFE, 18'h00001, 18'h30000, 18'h10000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_beat(ta[i], tb_[i], tc[i], ts[i]);
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL single_in_ready[%0d]: got %b, want 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
      for (int w = 0; w < 3; w++) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early_valid[%0d] cyc%0d: got %b, want 0", i, w, out_valid);
        end
        tick();
      end
      n_tests++;
      if (out_valid !== 1'b1 || {overflow, c_out, s} !== te[i]) begin
        n_fail++;
        $display("FAIL single_result[%0d]: got v=%b ov/c/s=%h, want v=1 ov/c/s=%h",
                 i, out_valid, {overflow, c_out, s}, te[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [17:0] te [3];
    te = '{18'h02345, 18'h00101, 18'h37FFF};
    out_ready = 1'b1;
    set_beat(16'h1234, 16'h1111, 1'b0, 1'b0); tick();
    set_beat(16'h00FF, 16'h0001, 1'b1, 1'b0); tick();
    set_beat(16'h8000, 16'h0001, 1'b0, 1'b1); tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || {overflow, c_out, s} !== te[i]) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got v=%b ov/c/s=%h, want v=1 ov/c/s=%h",
                 i, out_valid, {overflow, c_out, s}, te[i]);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [15:0] sa  [5];
    logic [15:0] sb  [5];
    logic [17:0] se  [5];
    sa = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'hA000};
    sb = '{16'h0001, 16'h0020, 16'h0300, 16'h5000, 16'h7000};
    se = '{18'h00002, 18'h00030, 18'h00400, 18'h06000, 18'h11000};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_beat(sa[i], sb[i], 1'b0, 1'b0);
      tick();
    end
    set_beat(sa[4], sb[4], 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {overflow, c_out, s} !== se[0]) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d: got rdy=%b v=%b ov/c/s=%h, want rdy=0 v=1 ov/c/s=%h",
                 w, in_ready, out_valid, {overflow, c_out, s}, se[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || {overflow, c_out, s} !== se[0]) begin
      n_fail++;
      $display("FAIL stall_release: got rdy=%b v=%b ov/c/s=%h, want rdy=1 v=1 ov/c/s=%h",
               in_ready, out_valid, {overflow, c_out, s}, se[0]);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || {overflow, c_out, s} !== se[i]) begin
        n_fail++;
        $display("FAIL stall_order[%0d]: got v=%b ov/c/s=%h, want v=1 ov/c/s=%h",
                 i, out_valid, {overflow, c_out, s}, se[i]);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_bubbles();
    logic        ev [4];
    logic [17:0] ee [4];
    ev = '{1'b1, 1'b0, 1'b1, 1'b0};
    ee = '{18'h00005, 18'h00000, 18'h100FF, 18'h00000};
    out_ready = 1'b1;
    set_beat(16'h0002, 16'h0003, 1'b0, 1'b0); tick();
    in_valid = 1'b0; tick();
    set_beat(16'h0100, 16'h0001, 1'b0, 1'b1); tick();
    in_valid = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== ev[i] || (ev[i] && {overflow, c_out, s} !== ee[i])) begin
        n_fail++;
        $display("FAIL bubble[%0d]: got v=%b ov/c/s=%h, want v=%b ov/c/s=%h",
                 i, out_valid, {overflow, c_out, s}, ev[i], ee[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(16'h0011 + 16'(i), 16'h0022, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_prefill: got v=%b, want 1", out_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || {overflow, c_out, s} !== 18'h0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: got v=%b rdy=%b ov/c/s=%h, want v=0 rdy=0 ov/c/s=00000",
               out_valid, in_ready, {overflow, c_out, s});
    end
    tick();
    reset = 1'b0;
    for (int w = 0; w < 6; w++) begin
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale cyc%0d: got v=%b, want 0", w, out_valid);
      end
      tick();
    end
    set_beat(16'h0102, 16'h0203, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_early cyc%0d: got v=%b, want 0", w, out_valid);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b1 || {overflow, c_out, s} !== 18'h00305) begin
      n_fail++;
      $display("FAIL rstmid_first: got v=%b ov/c/s=%h, want v=1 ov/c/s=00305",
               out_valid, {overflow, c_out, s});
    end
    tick();
  endtask

  task automatic test_random();
    logic [17:0] q[$];
    logic [17:0] exp_v;
    int          acc;
    int          cyc;
    acc = 0;
    cyc = 0;
    while ((acc < 10000 || q.size() > 0) && cyc < 70000) begin
      if (acc < 10000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        a         = 16'($urandom);
        b         = 16'($urandom);
        c_in      = 1'($urandom);
        sub       = 1'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got unexpected result %h, want none", {overflow, c_out, s});
        end else begin
          exp_v = q.pop_front();
          if ({overflow, c_out, s} !== exp_v) begin
            n_fail++;
            $display("FAIL rand_result: got ov/c/s=%h, want %h", {overflow, c_out, s}, exp_v);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, c_in, sub));
        acc++;
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (acc != 10000 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_timeout: got accepted=%0d pending=%0d, want accepted=10000 pending=0",
               acc, q.size());
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_beats();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16; operand width; multiple of 4, range 4..64.
REQ-002 SHALL have parameter GROUPS_PER_STAGE, default 1; 4-bit lookahead groups resolved per pipeline stage; SHALL divide WIDTH/4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have ports a and b  input  WIDTH  operands.
REQ-008 SHALL have port c_in  input  1  carry in; used only when sub=0.
REQ-009 SHALL have port sub  input  1  0 = a+b+c_in, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port s  output  WIDTH  sum/difference.
REQ-013 SHALL have port c_out  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL define L = WIDTH/(4*GROUPS_PER_STAGE); latency from accepted input to out_valid SHALL be exactly L cycles with no stall.
REQ-016 SHALL form effective operand b' = sub ? ~b : b and effective carry cin' = sub ? 1 : c_in at acceptance.
REQ-017 Each 4-bit group SHALL compute g = a&b', p = a|b', and group carries by full two-level lookahead (each carry a direct sum-of-products of g, p and group carry-in); s bits = a^b'^carry.
REQ-018 Within a stage, group carry-out SHALL feed next group's carry-in combinationally; between stages the carry SHALL be registered.
REQ-019 Stage k SHALL compute groups k*GROUPS_PER_STAGE .. (k+1)*GROUPS_PER_STAGE-1; unprocessed operand bits and completed sum bits SHALL be carried in stage registers (skew/deskew) so s emerges aligned.
REQ-020 c_out SHALL equal carry out of bit WIDTH-1; overflow SHALL equal carry into bit WIDTH-1 XOR c_out.
REQ-021 Each stage SHALL carry a valid bit; bubbles SHALL propagate without corrupting neighbouring beats.
REQ-022 Pipeline SHALL advance when NOT (out_valid AND NOT out_ready); otherwise all stages SHALL hold (global stall).
REQ-023 in_ready SHALL equal the advance condition; a beat is accepted iff in_valid AND in_ready.
REQ-024 s, c_out, overflow SHALL be registered outputs, held stable while out_valid=1 and out_ready=0.
REQ-025 Full throughput: with out_ready held 1, one beat SHALL be accepted and one delivered every cycle after fill.
REQ-026 Results SHALL emerge in acceptance order; no beat SHALL be dropped or duplicated.
REQ-027 Sum wrap-around SHALL be modulo 2^WIDTH, with carry reported only on c_out.

Reset
REQ-028 reset=1 SHALL asynchronously clear all stage valid bits, out_valid=0, s=0, c_out=0, overflow=0.
REQ-029 in_ready SHALL be 1 while reset is deasserted and pipeline empty; in_ready SHALL be 0 while reset=1.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; first beat accepted after deassertion SHALL appear L cycles later.

Verification (WIDTH=16, GROUPS_PER_STAGE=1, L=4)
REQ-031 a=0xFFFF, b=0x0001, c_in=0, sub=0 -> 4 cycles later s=0x0000, c_out=1, overflow=0.
REQ-032 a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, c_out=0, overflow=1; a=0x0003, b=0x0005, sub=1 -> s=0xFFFE, c_out=0, overflow=0.
REQ-033 Back-to-back beats 0x1234+0x1111, 0x00FF+0x0001+c_in=1, 0x8000-0x0001 with out_ready=1 -> consecutive outputs 0x2345, 0x0101, 0x7FFF(overflow=1, c_out=1).
REQ-034 out_ready=0 for 3 cycles with full pipeline -> in_ready=0, s held constant, no beat lost; order intact after release.
REQ-035 in_valid toggling 1,0,1 -> out_valid pattern 1,0,1 delayed by 4 cycles.
REQ-036 Assert reset with 3 beats in flight -> out_valid=0 immediately, no stale result after deassertion; random compare vs. a+b'+cin' model over 10k beats with random out_ready.
